// File: rtl/sobel_pipe_accelerator_pkg.sv
// ============================================================================
// Module  : sobel_pipe_accelerator_pkg
// Purpose : Shared constants and arithmetic helpers for the pipelined Sobel
//           accelerator (magnitude mode encodings, pixel width default,
//           signed gradient and absolute-value helpers).
// Ports   : none (package)
// Revision: 1.0 - initial pipelined release
// ============================================================================
`default_nettype none

package sobel_pipe_accelerator_pkg;

    localparam int PIX_W_DEFAULT = 8;

    localparam logic [1:0] SOBEL_MODE_L1     = 2'd0;
    localparam logic [1:0] SOBEL_MODE_THRESH = 2'd1;
    localparam logic [1:0] SOBEL_MODE_MAX    = 2'd2;

    // One Sobel axis: (p0 + 2*p1 + p2) - (n0 + 2*n1 + n2), range +/-1020.
    // Each weighted sum fits in 10 unsigned bits, so 12-bit signed holds the
    // difference without overflow before it is narrowed to 11 bits.
    function automatic logic signed [10:0] sobel_diff(
        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
        input logic [7:0] n0, input logic [7:0] n1, input logic [7:0] n2
    );
        logic signed [11:0] pos_sum;
        logic signed [11:0] neg_sum;
        logic signed [11:0] diff;
        pos_sum = $signed({4'd0, p0}) + $signed({3'd0, p1, 1'b0}) + $signed({4'd0, p2});
        neg_sum = $signed({4'd0, n0}) + $signed({3'd0, n1, 1'b0}) + $signed({4'd0, n2});
        diff    = pos_sum - neg_sum;
        return diff[10:0];
    endfunction

    // |v| for a gradient; the magnitude never exceeds 1020 so 10 bits suffice.
    function automatic logic [9:0] sobel_abs(input logic signed [10:0] v);
        logic signed [10:0] neg_v;
        neg_v = -v;
        return (v < 11'sd0) ? neg_v[9:0] : v[9:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sobel_pipe_accelerator_lane.sv
// ============================================================================
// Module  : sobel_lane
// Purpose : One Sobel convolution lane. Three registered stages sharing the
//           per-stage enables generated by the top-level flow control:
//           stage 1 gx/gy, stage 2 magnitude (L1 or max-norm), stage 3
//           saturated or thresholded output pixel.
// Ports   : clk, reset_n           - clock, synchronous active-low reset
//           i_en1/i_en2/i_en3      - stage load enables
//           i_top/i_mid/i_bot      - 3 pixels of each row, pixel 0 in LSBs
//           i_mode_s2              - mode travelling with the beat in stage 1
//           i_mode_s3/i_thresh_s3  - mode/threshold travelling in stage 2
//           o_pix                  - registered stage-3 output pixel
// Revision: 1.0 - initial pipelined release
// ============================================================================
`default_nettype none

module sobel_lane
    import sobel_pipe_accelerator_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_en1,
    input  logic       i_en2,
    input  logic       i_en3,
    input  logic [23:0] i_top,
    input  logic [23:0] i_mid,
    input  logic [23:0] i_bot,
    input  logic [1:0] i_mode_s2,
    input  logic [1:0] i_mode_s3,
    input  logic [7:0] i_thresh_s3,
    output logic [7:0] o_pix
);

    logic signed [10:0] r_gx;
    logic signed [10:0] r_gy;
    logic        [11:0] r_mag;

    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic        [9:0]  w_ax;
    logic        [9:0]  w_ay;
    logic        [11:0] w_l1;
    logic        [11:0] w_max;
    logic        [7:0]  w_pix;

    assign w_gx = sobel_diff(i_top[7:0],   i_top[15:8], i_top[23:16],
                             i_bot[7:0],   i_bot[15:8], i_bot[23:16]);
    assign w_gy = sobel_diff(i_top[23:16], i_mid[23:16], i_bot[23:16],
                             i_top[7:0],   i_mid[7:0],   i_bot[7:0]);

    assign w_ax  = sobel_abs(r_gx);
    assign w_ay  = sobel_abs(r_gy);
    assign w_l1  = {2'b00, w_ax} + {2'b00, w_ay};
    assign w_max = {2'b00, (w_ax >= w_ay) ? w_ax : w_ay};

    // Threshold mode compares the full 12-bit L1 value, not the saturated one.
    assign w_pix = (i_mode_s3 == SOBEL_MODE_THRESH)
                 ? ((r_mag >= {4'd0, i_thresh_s3}) ? 8'hFF : 8'h00)
                 : ((r_mag > 12'd255) ? 8'hFF : r_mag[7:0]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_gx  <= '0;
            r_gy  <= '0;
            r_mag <= '0;
            o_pix <= '0;
        end else begin
            if (i_en1) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
            if (i_en2) begin
                r_mag <= (i_mode_s2 == SOBEL_MODE_MAX) ? w_max : w_l1;
            end
            if (i_en3) begin
                o_pix <= w_pix;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sobel_pipe_accelerator.sv
// ============================================================================
// Module  : sobel_pipe_accelerator
// Purpose : 3-stage pipelined Sobel edge detector, NUM_LANES output pixels
//           per beat, valid/ready on both sides, per-beat configuration and a
//           saturating edge-pixel counter.
// Ports   : clk, reset_n                 - clock, synchronous active-low reset
//           in_valid/in_ready            - input beat handshake
//           row1_data/row2_data/row3_data- three rows, (NUM_LANES+2) pixels
//           cfg_mode/cfg_thresh          - captured with each accepted beat
//           out_valid/out_ready/out_data - output beat handshake and data
//           cnt_clear/edge_count         - edge counter clear and value
//           busy                         - any stage holds a valid beat
// Revision: 1.0 - initial pipelined release
// ============================================================================
`default_nettype none

module sobel_pipe_accelerator
    import sobel_pipe_accelerator_pkg::*;
#(
    parameter int NUM_LANES = 16,
    parameter int PIX_W     = PIX_W_DEFAULT,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(NUM_LANES+2)*PIX_W-1:0] row1_data,
    input  logic [(NUM_LANES+2)*PIX_W-1:0] row2_data,
    input  logic [(NUM_LANES+2)*PIX_W-1:0] row3_data,
    input  logic [1:0]                     cfg_mode,
    input  logic [7:0]                     cfg_thresh,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*PIX_W-1:0]     out_data,
    input  logic                           cnt_clear,
    output logic [CNT_W-1:0]               edge_count,
    output logic                           busy
);

    localparam int c_pc_w = $clog2(NUM_LANES + 1);

    generate
        if (PIX_W != 8) begin : g_bad_pix_w
            $error("sobel_pipe_accelerator: PIX_W must be 8");
        end
        if (NUM_LANES < 1 || NUM_LANES > 32) begin : g_bad_lanes
            $error("sobel_pipe_accelerator: NUM_LANES must be 1..32");
        end
    endgenerate

    logic              r_v1, r_v2, r_v3;
    logic [1:0]        r_mode1, r_mode2;
    logic [7:0]        r_thresh1, r_thresh2, r_thresh3;
    logic [CNT_W-1:0]  r_edge_count;

    logic              w_ld1, w_ld2, w_ld3;
    logic              w_en1, w_en2, w_en3;
    logic              w_out_hs;
    logic [c_pc_w-1:0] w_pop;
    logic [CNT_W:0]    w_sum;

    // A stage may load when it is empty or its beat leaves this cycle; the
    // chain runs combinationally from out_ready so bubbles collapse.
    assign w_ld3 = !r_v3 | out_ready;
    assign w_ld2 = !r_v2 | w_ld3;
    assign w_ld1 = !r_v1 | w_ld2;

    // Data registers only move when a real beat arrives, so out_data keeps its
    // last value across bubbles.
    assign w_en1 = w_ld1 & in_valid;
    assign w_en2 = w_ld2 & r_v1;
    assign w_en3 = w_ld3 & r_v2;

    assign in_ready   = w_ld1;
    assign out_valid  = r_v3;
    assign busy       = r_v1 | r_v2 | r_v3;
    assign edge_count = r_edge_count;
    assign w_out_hs   = r_v3 & out_ready;

    genvar c;
    generate
        for (c = 0; c < NUM_LANES; c++) begin : g_lanes
            sobel_lane u_lane (
                .clk         (clk),
                .reset_n     (reset_n),
                .i_en1       (w_en1),
                .i_en2       (w_en2),
                .i_en3       (w_en3),
                .i_top       (row1_data[c*PIX_W +: 3*PIX_W]),
                .i_mid       (row2_data[c*PIX_W +: 3*PIX_W]),
                .i_bot       (row3_data[c*PIX_W +: 3*PIX_W]),
                .i_mode_s2   (r_mode1),
                .i_mode_s3   (r_mode2),
                .i_thresh_s3 (r_thresh2),
                .o_pix       (out_data[c*PIX_W +: PIX_W])
            );
        end
    endgenerate

    // Edge pixels of the beat currently presented, judged against the
    // threshold that was captured with that beat.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (out_data[k*PIX_W +: PIX_W] >= r_thresh3) begin
                w_pop = w_pop + c_pc_w'(1);
            end
        end
    end

    assign w_sum = {1'b0, r_edge_count} + {{(CNT_W+1-c_pc_w){1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            r_mode1      <= '0;
            r_mode2      <= '0;
            r_thresh1    <= '0;
            r_thresh2    <= '0;
            r_thresh3    <= '0;
            r_edge_count <= '0;
        end else begin
            if (w_ld1) r_v1 <= in_valid;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld3) r_v3 <= r_v2;

            if (w_en1) begin
                r_mode1   <= cfg_mode;
                r_thresh1 <= cfg_thresh;
            end
            if (w_en2) begin
                r_mode2   <= r_mode1;
                r_thresh2 <= r_thresh1;
            end
            if (w_en3) begin
                r_thresh3 <= r_thresh2;
            end

            // Clear wins, but a beat leaving in the same cycle is still counted.
            if (cnt_clear) begin
                r_edge_count <= w_out_hs ? {{(CNT_W-c_pc_w){1'b0}}, w_pop} : '0;
            end else if (w_out_hs) begin
                r_edge_count <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_pipe_accelerator.sv
// ============================================================================
// Module  : tb_sobel_pipe_accelerator
// Purpose : Scoreboard bench for sobel_pipe_accelerator with NUM_LANES=4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sobel_pipe_accelerator;

    localparam int NL = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [47:0]       row1_data, row2_data, row3_data;
    logic [1:0]        cfg_mode;
    logic [7:0]        cfg_thresh;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              cnt_clear;
    logic [31:0]       edge_count;
    logic              busy;

    sobel_pipe_accelerator #(.NUM_LANES(NL), .PIX_W(8), .CNT_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .row1_data  (row1_data),
        .row2_data  (row2_data),
        .row3_data  (row3_data),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cnt_clear  (cnt_clear),
        .edge_count (edge_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          pop;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          or_mode = 0;
    int          bp_idx  = 0;
    bit          lat_flag = 1'b0;
    logic [31:0] exp_cnt = '0;
    bit          stall_prev = 1'b0;
    logic [31:0] held_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference Sobel model, integer arithmetic.
    function automatic logic [31:0] model(input logic [47:0] r1, input logic [47:0] r2,
                                          input logic [47:0] r3, input logic [1:0] m,
                                          input logic [7:0] t);
        logic [31:0] res;
        int a[6], b[6], d[6];
        for (int k = 0; k < 6; k++) begin
            a[k] = int'(r1[k*8 +: 8]);
            b[k] = int'(r2[k*8 +: 8]);
            d[k] = int'(r3[k*8 +: 8]);
        end
        res = '0;
        for (int c = 0; c < NL; c++) begin
            int gx, gy, ax, ay, l1, mx, px;
            gx = (a[c] + 2*a[c+1] + a[c+2]) - (d[c] + 2*d[c+1] + d[c+2]);
            gy = (a[c+2] + 2*b[c+2] + d[c+2]) - (a[c] + 2*b[c] + d[c]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
            l1 = ax + ay;
            mx = (ax > ay) ? ax : ay;
            if (m == 2'd1)      px = (l1 >= int'(t)) ? 255 : 0;
            else if (m == 2'd2) px = (mx > 255) ? 255 : mx;
            else                px = (l1 > 255) ? 255 : l1;
            res[c*8 +: 8] = px[7:0];
        end
        return res;
    endfunction

    function automatic int popc(input logic [31:0] v, input logic [7:0] t);
        int n = 0;
        for (int c = 0; c < NL; c++) if (v[c*8 +: 8] >= t) n++;
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: 0=always ready, 1=repeating 1,0,0,1, 2=stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ((bp_idx % 4) == 0) || ((bp_idx % 4) == 3);
                    bp_idx++;
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard: sampled on the falling edge, describing the
    // transfers that happen on the next rising edge.
    always @(negedge clk) begin
        bit          hs;
        int          pop;
        exp_t        e;
        logic [32:0] s;
        if (!reset_n) begin
            sb.delete();
            exp_cnt    = '0;
            stall_prev = 1'b0;
        end else begin
            check("in_ready", {63'd0, in_ready}, {63'd0, !(sb.size() == 3 && !out_ready)});
            check("busy", {63'd0, busy}, {63'd0, sb.size() != 0});
            check("edge_count", {32'd0, edge_count}, {32'd0, exp_cnt});
            if (sb.size() == 0) check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
            if (stall_prev) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_data", {32'd0, out_data}, {32'd0, held_data});
            end
            hs  = out_valid && out_ready;
            pop = 0;
            if (hs && sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", {32'd0, out_data}, {32'd0, e.data});
                if (e.lat) check("latency", 64'(cyc + 1 - e.acc), 64'd3);
                pop = e.pop;
            end
            if (cnt_clear) begin
                exp_cnt = hs ? 32'(pop) : 32'd0;
            end else if (hs) begin
                s = {1'b0, exp_cnt} + 33'(pop);
                exp_cnt = s[32] ? 32'hFFFF_FFFF : s[31:0];
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            if (in_valid && in_ready) begin
                e.data = model(row1_data, row2_data, row3_data, cfg_mode, cfg_thresh);
                e.pop  = popc(e.data, cfg_thresh);
                e.acc  = cyc + 1;
                e.lat  = lat_flag;
                sb.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic send(input logic [47:0] r1, input logic [47:0] r2, input logic [47:0] r3,
                        input logic [1:0] m, input logic [7:0] t);
        int n = 0;
        in_valid   = 1'b1;
        row1_data  = r1;
        row2_data  = r2;
        row3_data  = r3;
        cfg_mode   = m;
        cfg_thresh = t;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    localparam logic [47:0] ROW_ZERO = 48'h0;
    localparam logic [47:0] ROW_200  = 48'hC8C8C8C8C8C8;
    localparam logic [47:0] ROW_RAMP = 48'h3C32281E140A;
    localparam logic [47:0] ROW_EDGE = 48'h323232000000;

    initial begin
        logic [63:0] rnd1, rnd2, rnd3;
        int n;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        row1_data  = '0;
        row2_data  = '0;
        row3_data  = '0;
        cfg_mode   = '0;
        cfg_thresh = '0;
        cnt_clear  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_edge_count", {32'd0, edge_count}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Strong horizontal edge, back-to-back, latency checked.
        lat_flag = 1'b1;
        repeat (3) send(ROW_ZERO, ROW_ZERO, ROW_200, 2'd0, 8'd128);
        idle();
        lat_flag = 1'b0;
        drain();

        // Ramp: L1 and max-norm both give 80 per lane.
        send(ROW_RAMP, ROW_RAMP, ROW_RAMP, 2'd0, 8'd50);
        send(ROW_RAMP, ROW_RAMP, ROW_RAMP, 2'd2, 8'd50);
        send(ROW_RAMP, ROW_RAMP, ROW_RAMP, 2'd3, 8'd90);
        idle();
        drain();

        // Threshold mode on a vertical edge, then config changing beat to beat.
        send(ROW_EDGE, ROW_EDGE, ROW_EDGE, 2'd1, 8'd100);
        send(ROW_EDGE, ROW_EDGE, ROW_EDGE, 2'd0, 8'd100);
        send(ROW_EDGE, ROW_EDGE, ROW_EDGE, 2'd1, 8'd100);
        idle();
        drain();

        // Backpressure with distinct random beats.
        or_mode = 1;
        bp_idx  = 0;
        for (int i = 0; i < 10; i++) begin
            rnd1 = {$urandom(), $urandom()};
            rnd2 = {$urandom(), $urandom()};
            rnd3 = {$urandom(), $urandom()};
            send(rnd1[47:0], rnd2[47:0], rnd3[47:0], 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)));
        end
        idle();
        drain();
        or_mode = 0;

        // Counter clear coinciding with an output handshake of 2 edge lanes.
        or_mode = 2;
        send(ROW_EDGE, ROW_EDGE, ROW_EDGE, 2'd1, 8'd100);
        idle();
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("clear_wait_timeout", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        or_mode   = 0;
        cnt_clear = 1'b1;
        @(posedge clk);
        #1 cnt_clear = 1'b0;
        @(negedge clk);
        check("clear_with_hs", {32'd0, edge_count}, 64'd2);
        @(posedge clk);
        #1;

        // Reset with three beats stuck in the pipe.
        or_mode = 2;
        repeat (3) send(ROW_ZERO, ROW_ZERO, ROW_200, 2'd0, 8'd10);
        idle();
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        or_mode = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("post_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("post_rst_edge_count", {32'd0, edge_count}, 64'd0);
        check("post_rst_busy", {63'd0, busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sobel_pipe_accelerator.md
Name: sobel_pipe_accelerator

Overview:
Pipelined, parametrised successor to the combinational Sobel accelerator core. It accepts one beat of three image rows, (NUM_LANES+2) pixels each, over a valid/ready handshake, and emits NUM_LANES output pixels per beat after a 3-stage registered pipeline. It adds selectable magnitude modes, a binary threshold mode, backpressure support and an edge-pixel counter. It sits between the row-register block and the output write buffer.

Parameters:
NUM_LANES, 16, output pixels per beat (parallel convolution cores); legal values 1..32
PIX_W, 8, bits per pixel; fixed at 8 for this revision, with other values rejected by elaboration assertion
CNT_W, 32, width of edge_count

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset; single clock domain
in_valid  in  1  input beat valid
in_ready  out  1  core can accept a beat this cycle
row1_data  in  (NUM_LANES+2)*PIX_W  top row; pixel k at bits [k*8+7:k*8]
row2_data  in  (NUM_LANES+2)*PIX_W  middle row
row3_data  in  (NUM_LANES+2)*PIX_W  bottom row
cfg_mode  in  2  0=L1 saturate, 1=threshold, 2=max-norm saturate, 3=treated as 0
cfg_thresh  in  8  threshold for mode 1 and for edge counting
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  NUM_LANES*PIX_W  result; lane c at bits [c*8+7:c*8]
cnt_clear  in  1  synchronous clear of edge_count
edge_count  out  CNT_W  count of output pixels >= cfg_thresh
busy  out  1  high when any pipeline stage holds a valid beat

Behaviour:
- Reset (reset_n=0 at a clk edge): all stage valid bits are 0. out_valid=0, out_data=0, edge_count=0, busy=0. in_ready is 1 in the first cycle after reset. Reset mid-operation discards in-flight beats with no output.
- Lane c window: columns c, c+1, c+2 of each row. a=row1, b=row2, d=row3.
- gx = (a[c]+2a[c+1]+a[c+2]) - (d[c]+2d[c+1]+d[c+2]).
- gy = (a[c+2]+2b[c+2]+d[c+2]) - (a[c]+2b[c]+d[c]).
- gx and gy are signed 11-bit, range ±1020. All intermediates use explicit signed arithmetic. An unsigned compare against 0 is a defect.
- Stage 1: register gx, gy for all lanes, plus cfg_mode and cfg_thresh captured at acceptance. Config therefore travels with its beat; mid-stream config changes affect only later beats.
- Stage 2: register |gx|+|gy| (12-bit unsigned) for mode 0/3, or max(|gx|,|gy|) for mode 2. Mode 1 uses the L1 value.
- Stage 3: saturate to 255 in modes 0/2/3. In mode 1 the output is 255 if the L1 value >= thresh, else 0. Register into out_data.
- Latency: exactly 3 cycles from input handshake to out_valid when there is no backpressure. Throughput is 1 beat per cycle.
- Handshake: a beat transfers when valid and ready are both high on a clk edge.
  - Stage k loads when it is empty or its contents advance this cycle, so bubbles collapse.
  - in_ready = !v1 | (v2 advancing or !v2), chained combinationally from out_ready.
  - in_ready does not depend on in_valid.
  - out_valid and out_data hold stable while out_ready=0.
  - No beat is lost or duplicated under any valid/ready pattern.
- edge_count:
  - On each output handshake, add the number of lanes whose out_data byte >= that beat's captured thresh.
  - The count saturates at 2^CNT_W-1.
  - cnt_clear has priority. If cnt_clear coincides with a handshake, edge_count is set to that beat's popcount, not 0.
- busy = v1|v2|v3.

Decomposition:
- The shared defines file gains SOBEL_MODE_L1=0, SOBEL_MODE_THRESH=1 and SOBEL_MODE_MAX=2, plus the PIX_W default.
- One natural sub-module, sobel_lane, is instantiated NUM_LANES times via generate. It takes the 3x3 window plus mode and thresh, and returns registered gx/gy and the stage-2/3 values under a shared per-stage enable.
- Valid/ready control, config pipeline and counter live in the top module.

Test Plan:
- NUM_LANES=4, mode 0, a=all 0, b=all 0, d=all 200, valid every cycle, out_ready=1 -> out_data=0xFFFFFFFF (gx=-800), exactly 3 cycles after accept. in_ready stays 1.
- Mode 0, a=b=d=[10,20,30,40,50,60] (pixel 0 first), gx=0, gy=80 -> each lane 80, out_data=0x50505050. Mode 2 on the same input -> 0x50505050.
- Mode 1, thresh=100, vertical edge (columns 0-2 = 0, columns 3-5 = 50, all rows) -> lanes with gy=200 output 0xFF, other lanes 0x00. edge_count increments by the number of 0xFF lanes.
- Backpressure: 10 beats with distinct data, out_ready toggling 1,0,0,1 pattern -> all 10 outputs in order, no duplicates. out_data is stable while stalled. in_ready=0 only when all 3 stages are full and out_ready=0.
- Config in flight: switch cfg_mode 0->1 on consecutive input beats -> output beat 1 uses L1 and beat 2 uses threshold.
- Reset: reset_n low for 1 cycle with 3 beats in flight -> no out_valid afterwards, edge_count=0. cnt_clear coinciding with a handshake of 2 edge lanes -> edge_count=2.
